// File: rtl/music_ctrl_n.sv
// Playback controller: song selection, play/pause, player reset pulse,
// NewFrame synchronisation and a pausable beat divider.
module music_ctrl_n #(
  parameter int SONGS     = 4,
  parameter int SONG_BITS = 2,
  parameter int BEAT_DIV  = 1000,
  parameter int DIV_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_pause,
  input  logic                 next,
  input  logic                 prev,
  input  logic [1:0]           mode,
  input  logic                 song_done,
  input  logic                 NewFrame,
  output logic [SONG_BITS-1:0] song,
  output logic                 play,
  output logic                 reset_play,
  output logic                 sample_tick,
  output logic                 beat
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_PLAYING = 2'd2,
    ST_LOAD    = 2'd3
  } state_t;

  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(SONGS - 1);
  localparam logic [DIV_BITS-1:0]  LAST_CNT  = DIV_BITS'(BEAT_DIV - 1);
  localparam logic [1:0] MODE_SEQ      = 2'b00;
  localparam logic [1:0] MODE_REPEAT   = 2'b01;
  localparam logic [1:0] MODE_ALL_ONCE = 2'b10;
  localparam logic [1:0] MODE_SINGLE   = 2'b11;

  state_t               state_r;
  state_t               resume_r;
  logic [SONG_BITS-1:0] song_r;
  logic [DIV_BITS-1:0]  cnt_r;
  logic                 f1_r, f2_r, f3_r;
  logic                 next_only_s, prev_only_s;

  function automatic logic [SONG_BITS-1:0] song_inc(input logic [SONG_BITS-1:0] cur);
    return (cur == LAST_SONG) ? {SONG_BITS{1'b0}} : cur + SONG_BITS'(1);
  endfunction

  function automatic logic [SONG_BITS-1:0] song_dec(input logic [SONG_BITS-1:0] cur);
    return (cur == {SONG_BITS{1'b0}}) ? LAST_SONG : cur - SONG_BITS'(1);
  endfunction

  // next and prev together cancel each other
  assign next_only_s = next & ~prev;
  assign prev_only_s = prev & ~next;

  assign song        = song_r;
  assign play        = (state_r == ST_PLAYING);
  assign reset_play  = (state_r == ST_INIT) || (state_r == ST_LOAD);
  assign sample_tick = f2_r & ~f3_r;
  assign beat        = sample_tick & play & (cnt_r == LAST_CNT);

  // Control FSM: state, resume target and song index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_INIT;
      resume_r <= ST_PAUSED;
      song_r   <= {SONG_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: state_r <= ST_PAUSED;
        ST_PAUSED: begin
          if (next_only_s || prev_only_s) begin
            song_r   <= next_only_s ? song_inc(song_r) : song_dec(song_r);
            resume_r <= ST_PAUSED;
            state_r  <= ST_LOAD;
          end else if (play_pause) begin
            state_r <= ST_PLAYING;
          end else begin
            state_r <= ST_PAUSED;
          end
        end
        ST_PLAYING: begin
          if (next_only_s || prev_only_s) begin
            song_r   <= next_only_s ? song_inc(song_r) : song_dec(song_r);
            resume_r <= ST_PLAYING;
            state_r  <= ST_LOAD;
          end else if (song_done) begin
            state_r <= ST_LOAD;
            case (mode)
              MODE_SEQ: begin
                song_r   <= song_inc(song_r);
                resume_r <= ST_PLAYING;
              end
              MODE_REPEAT: resume_r <= ST_PLAYING;
              MODE_ALL_ONCE: begin
                song_r   <= song_inc(song_r);
                resume_r <= (song_r == LAST_SONG) ? ST_PAUSED : ST_PLAYING;
              end
              MODE_SINGLE: resume_r <= ST_PAUSED;
              default:     resume_r <= ST_PAUSED;
            endcase
          end else if (play_pause) begin
            state_r <= ST_PAUSED;
          end else begin
            state_r <= ST_PLAYING;
          end
        end
        ST_LOAD: state_r <= resume_r;
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // NewFrame three-flop synchroniser and edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f1_r <= 1'b0;
      f2_r <= 1'b0;
      f3_r <= 1'b0;
    end else begin
      f1_r <= NewFrame;
      f2_r <= f1_r;
      f3_r <= f2_r;
    end
  end

  // Beat divider: holds phase while paused, restarts on every player reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {DIV_BITS{1'b0}};
    end else if (reset_play) begin
      cnt_r <= {DIV_BITS{1'b0}};
    end else if (sample_tick && play) begin
      cnt_r <= (cnt_r == LAST_CNT) ? {DIV_BITS{1'b0}} : cnt_r + DIV_BITS'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_music_ctrl_n.sv
// Directed self-checking bench for music_ctrl_n with SONGS=3, BEAT_DIV=4.
module tb_music_ctrl_n;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_pause = 1'b0, next = 1'b0, prev = 1'b0, song_done = 1'b0, NewFrame = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] song;
  logic       play, reset_play, sample_tick, beat;
  int         n_checks = 0;
  int         n_fails  = 0;
  logic       bt;

  music_ctrl_n #(.SONGS(3), .SONG_BITS(2), .BEAT_DIV(4), .DIV_BITS(3)) dut (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
    .mode(mode), .song_done(song_done), .NewFrame(NewFrame), .song(song),
    .play(play), .reset_play(reset_play), .sample_tick(sample_tick), .beat(beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic nx, input logic pv, input logic pp, input logic sd);
    next = nx; prev = pv; play_pause = pp; song_done = sd;
    step();
    next = 1'b0; prev = 1'b0; play_pause = 1'b0; song_done = 1'b0;
  endtask

  // One NewFrame rising edge; returns beat seen while sample_tick is high
  task automatic frame(output logic b);
    NewFrame = 1'b1;
    step();
    step();
    chk("tick_hi", {31'd0, sample_tick}, 32'd1);
    b = beat;
    NewFrame = 1'b0;
    step();
  endtask

  task automatic chk_state(input string tag, input logic [1:0] s, input logic p, input logic r);
    chk({tag, "_song"}, {30'd0, song}, {30'd0, s});
    chk({tag, "_play"}, {31'd0, play}, {31'd0, p});
    chk({tag, "_rstp"}, {31'd0, reset_play}, {31'd0, r});
  endtask

  initial begin
    // 1: reset and release
    step(); step();
    chk_state("rst", 2'd0, 1'b0, 1'b1);
    chk("rst_tick", {31'd0, sample_tick}, 32'd0);
    chk("rst_beat", {31'd0, beat}, 32'd0);
    reset = 1'b1;
    #1;
    chk("init_rstp", {31'd0, reset_play}, 32'd1);
    step();
    chk_state("paused", 2'd0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("pp_play", 2'd0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("pp_pause", 2'd0, 1'b0, 1'b0);

    // 2: next x3 and prev while paused
    pulse(1'b1, 1'b0, 1'b0, 1'b0); chk_state("nx1", 2'd1, 1'b0, 1'b1);
    step();                        chk_state("nx1b", 2'd1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0); chk_state("nx2", 2'd2, 1'b0, 1'b1);
    step();                        chk_state("nx2b", 2'd2, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0); chk_state("nx3", 2'd0, 1'b0, 1'b1);
    step();                        chk_state("nx3b", 2'd0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0); chk_state("pv", 2'd2, 1'b0, 1'b1);
    step();                        chk_state("pvb", 2'd2, 1'b0, 1'b0);

    // 3: beat divider, pause holds phase
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("play3", 2'd2, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      frame(bt);
      chk($sformatf("beat_%0d", i), {31'd0, bt}, (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    frame(bt); chk("beat_pre1", {31'd0, bt}, 32'd0);
    frame(bt); chk("beat_pre2", {31'd0, bt}, 32'd0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("paused3", {31'd0, play}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      frame(bt);
      chk($sformatf("beat_paused_%0d", i), {31'd0, bt}, 32'd0);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frame(bt); chk("beat_res1", {31'd0, bt}, 32'd0);
    frame(bt); chk("beat_res2", {31'd0, bt}, 32'd1);

    // 4: end-of-song modes at song 2
    mode = 2'b00;
    pulse(1'b0, 1'b0, 1'b0, 1'b1); chk_state("seq", 2'd0, 1'b0, 1'b1);
    step();                        chk_state("seq_b", 2'd0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0); step();
    mode = 2'b01;
    pulse(1'b0, 1'b0, 1'b0, 1'b1); chk_state("rep", 2'd2, 1'b0, 1'b1);
    step();                        chk_state("rep_b", 2'd2, 1'b1, 1'b0);
    mode = 2'b10;
    pulse(1'b0, 1'b0, 1'b0, 1'b1); step();
    chk_state("allonce", 2'd0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0); step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("pre_single", 2'd2, 1'b1, 1'b0);
    mode = 2'b11;
    pulse(1'b0, 1'b0, 1'b0, 1'b1); step();
    chk_state("single", 2'd2, 1'b0, 1'b0);

    // 5: simultaneous inputs
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    mode = 2'b01;
    pulse(1'b1, 1'b0, 1'b0, 1'b1); step();
    chk_state("nx_done", 2'd0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    chk_state("nx_pv_pp", 2'd0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("load_in", 2'd1, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("pp_in_load", 2'd1, 1'b0, 1'b0);
    step();
    chk("pp_in_load_b", {31'd0, play}, 32'd0);

    // 6: async reset mid-song with cnt=3
    pulse(1'b1, 1'b0, 1'b0, 1'b0); step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("pre_rst", 2'd2, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) frame(bt);
    NewFrame = 1'b1;
    step(); step();
    #2 reset = 1'b0;
    #1;
    chk_state("async_rst", 2'd0, 1'b0, 1'b1);
    chk("async_tick", {31'd0, sample_tick}, 32'd0);
    chk("async_beat", {31'd0, beat}, 32'd0);
    NewFrame = 1'b0;
    step();
    reset = 1'b1;
    step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("post_rst", 2'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      frame(bt);
      chk($sformatf("beat_post_%0d", i), {31'd0, bt}, (i == 4) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
